// File: rtl/odometer_meas_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// odometer_pkg
// Shared definitions for the HVT ring-oscillator aging odometer controller.
//   meas_state_t : measurement FSM states
//   DRAIN_CYC    : cycles spent flushing the synchronisers after counting
//   SYNC_STAGES  : depth of the ROSC input synchronisers
// ----------------------------------------------------------------------------
package odometer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        DRAIN,
        DONE
    } meas_state_t;

    localparam int DRAIN_CYC   = 3;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/odometer_meas_ctrl_if.sv
// ----------------------------------------------------------------------------
// odometer_meas_ctrl_if
// Request / result bundle of the odometer measurement controller.
//   start     : one-cycle measurement request
//   chSel     : ROSC pair to measure
//   winLen    : counting window in clock cycles
//   acStress  : 1 = stress ROSCs free-run while idle, 0 = DC stress
//   roscRef   : divided reference ROSC outputs (asynchronous)
//   roscStr   : divided stress ROSC outputs (asynchronous)
//   refEn     : reference ROSC enables
//   strEn     : stress ROSC enables
//   busy      : measurement in progress
//   done      : one-cycle pulse, results valid
//   refCnt    : reference rising-edge count
//   strCnt    : stress rising-edge count
//   diff      : signed refCnt - strCnt
//   sat       : {ref saturated, stress saturated}
// master drives requests and oscillator inputs, slave is the controller.
// ----------------------------------------------------------------------------
interface odometer_meas_ctrl_if #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16
);

    logic              start;
    logic [CH_W-1:0]   chSel;
    logic [WIN_W-1:0]  winLen;
    logic              acStress;
    logic [NUM_CH-1:0] roscRef;
    logic [NUM_CH-1:0] roscStr;
    logic [NUM_CH-1:0] refEn;
    logic [NUM_CH-1:0] strEn;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  refCnt;
    logic [CNT_W-1:0]  strCnt;
    logic [CNT_W:0]    diff;
    logic [1:0]        sat;

    modport master (
        output start, chSel, winLen, acStress, roscRef, roscStr,
        input  refEn, strEn, busy, done, refCnt, strCnt, diff, sat
    );

    modport slave (
        input  start, chSel, winLen, acStress, roscRef, roscStr,
        output refEn, strEn, busy, done, refCnt, strCnt, diff, sat
    );

endinterface

// File: rtl/odometer_meas_ctrl_edge_cnt.sv
// ----------------------------------------------------------------------------
// odometer_edge_cnt
// Synchronises one asynchronous divided ROSC output, detects its rising
// edges and counts them into a saturating counter with a sticky flag.
//   i_clk    : system clock
//   i_rstn   : synchronous active-low reset
//   i_rosc   : asynchronous oscillator input
//   i_clr    : clears count and saturation flag for a new measurement
//   i_cntEn  : edges are counted only while high
//   o_cnt    : rising-edge count
//   o_sat    : set when an edge arrived while the count was already all-ones
// ----------------------------------------------------------------------------
module odometer_edge_cnt
    import odometer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_rosc,
    input  logic             i_clr,
    input  logic             i_cntEn,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sat;
    logic                   w_rise;

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Synchroniser chain plus one extra flop holding the previous
    // synchronised level, so a rise is a 0->1 step between the two.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rosc};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Counter holds at all-ones once full; the flag records that an edge
    // was lost and stays set until the next clear.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_cntEn && w_rise) begin
            if (&r_cnt) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule

// File: rtl/odometer_meas_ctrl.sv
// ----------------------------------------------------------------------------
// odometer_meas_ctrl
// Measurement and stress controller for the HVT ring-oscillator aging
// odometer. Between measurements the stress ROSCs are held in DC or AC
// stress; on request one ref/stress pair is enabled, allowed to settle,
// its edges counted over a programmable window, and the two counts,
// their signed difference and saturation flags are reported.
//   i_clk   : system clock
//   i_rstn  : synchronous active-low reset
//   io_bus  : request/result bundle (slave side), see odometer_meas_ctrl_if
// ----------------------------------------------------------------------------
module odometer_meas_ctrl
    import odometer_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 2,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    odometer_meas_ctrl_if.slave  io_bus
);

    // One down-counter serves settle, window and drain phases, so it must
    // be wide enough for the longest of the three.
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYC + 1);
    localparam int TMP_W  = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam int TMR_W  = (TMP_W > DRN_W) ? TMP_W : DRN_W;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    meas_state_t       r_state;
    logic [CH_W-1:0]   r_chSel;
    logic [WIN_W-1:0]  r_winLen;
    logic [TMR_W-1:0]  r_timer;
    logic [NUM_CH-1:0] r_refEn;
    logic [NUM_CH-1:0] r_strEn;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_refCnt;
    logic [CNT_W-1:0]  r_strCnt;
    logic [CNT_W:0]    r_diff;
    logic [1:0]        r_sat;

    logic              w_accept;
    logic              w_cntEn;
    logic              w_refSel;
    logic              w_strSel;
    logic [NUM_CH-1:0] w_reqOneHot;
    logic [CNT_W-1:0]  w_refCnt;
    logic [CNT_W-1:0]  w_strCnt;
    logic              w_refSat;
    logic              w_strSat;

    // Out-of-range channel requests are dropped without any handshake.
    assign w_accept = (r_state == IDLE) && io_bus.start &&
                      ({1'b0, io_bus.chSel} < NUM_CH_L);
    assign w_cntEn  = (r_state == COUNT);

    // Requested-channel one-hot for the enables, and the channel mux that
    // routes the latched pair into the edge counters.
    always_comb begin
        w_reqOneHot = '0;
        w_refSel    = 1'b0;
        w_strSel    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (io_bus.chSel == CH_W'(c)) begin
                w_reqOneHot[c] = 1'b1;
            end
            if (r_chSel == CH_W'(c)) begin
                w_refSel = io_bus.roscRef[c];
                w_strSel = io_bus.roscStr[c];
            end
        end
    end

    odometer_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_refCnt (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_rosc  (w_refSel),
        .i_clr   (w_accept),
        .i_cntEn (w_cntEn),
        .o_cnt   (w_refCnt),
        .o_sat   (w_refSat)
    );

    odometer_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_strCnt (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_rosc  (w_strSel),
        .i_clr   (w_accept),
        .i_cntEn (w_cntEn),
        .o_cnt   (w_strCnt),
        .o_sat   (w_strSat)
    );

    // Measurement sequencer. The timer is loaded with (length - 1) on entry
    // to each timed phase, so a phase lasts exactly its length in cycles.
    // A zero window skips COUNT entirely. Enables drop on entry to DRAIN so
    // the synchronisers flush while the oscillators stop; AC stress is
    // restored on the way back to IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            r_chSel  <= '0;
            r_winLen <= '0;
            r_timer  <= '0;
            r_refEn  <= '0;
            r_strEn  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_refCnt <= '0;
            r_strCnt <= '0;
            r_diff   <= '0;
            r_sat    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_chSel  <= io_bus.chSel;
                        r_winLen <= io_bus.winLen;
                        r_timer  <= TMR_W'(SETTLE_CYC - 1);
                        r_refEn  <= w_reqOneHot;
                        r_strEn  <= w_reqOneHot;
                        r_busy   <= 1'b1;
                        r_state  <= SETTLE;
                    end else begin
                        r_refEn  <= '0;
                        r_strEn  <= {NUM_CH{io_bus.acStress}};
                    end
                end
                SETTLE: begin
                    if (r_timer == '0) begin
                        if (r_winLen == '0) begin
                            r_timer <= TMR_W'(DRAIN_CYC - 1);
                            r_refEn <= '0;
                            r_strEn <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_timer <= TMR_W'(r_winLen) - TMR_W'(1);
                            r_state <= COUNT;
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                COUNT: begin
                    if (r_timer == '0) begin
                        r_timer <= TMR_W'(DRAIN_CYC - 1);
                        r_refEn <= '0;
                        r_strEn <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                DRAIN: begin
                    if (r_timer == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                DONE: begin
                    r_refCnt <= w_refCnt;
                    r_strCnt <= w_strCnt;
                    r_diff   <= {1'b0, w_refCnt} - {1'b0, w_strCnt};
                    r_sat    <= {w_refSat, w_strSat};
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_strEn  <= {NUM_CH{io_bus.acStress}};
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.refEn  = r_refEn;
    assign io_bus.strEn  = r_strEn;
    assign io_bus.busy   = r_busy;
    assign io_bus.done   = r_done;
    assign io_bus.refCnt = r_refCnt;
    assign io_bus.strCnt = r_strCnt;
    assign io_bus.diff   = r_diff;
    assign io_bus.sat    = r_sat;

endmodule

// File: tb/tb_odometer_meas_ctrl.sv
// ----------------------------------------------------------------------------
// tb_odometer_meas_ctrl
// Directed bench for odometer_meas_ctrl: a table of measurements with
// hand-computed counts and latencies, plus sequences for overlapping
// requests, AC_STRESS changes while busy, reset mid-count and saturation
// (second instance with a 4-bit counter).
// ----------------------------------------------------------------------------
module tb_odometer_meas_ctrl;

    typedef struct {
        logic [1:0] chSel;
        int         winLen;
        int         refPer;
        int         strPer;
        bit         accept;
        int         refMin;
        int         refMax;
        int         strExp;
        int         diffMin;
        int         diffMax;
    } vec_t;

    logic clk;
    logic rstn;
    logic [2:0] roscRef;
    logic [2:0] roscStr;
    int   refPer [3];
    int   strPer [3];
    int   tick;
    int   checks;
    int   errors;

    odometer_meas_ctrl_if #(.NUM_CH(3), .CH_W(2), .CNT_W(16), .WIN_W(16)) bus ();
    odometer_meas_ctrl_if #(.NUM_CH(3), .CH_W(2), .CNT_W(4),  .WIN_W(16)) busSat ();

    odometer_meas_ctrl #(
        .NUM_CH(3), .CH_W(2), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(8)
    ) u_dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_bus (bus.slave)
    );

    odometer_meas_ctrl #(
        .NUM_CH(3), .CH_W(2), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(8)
    ) u_dutSat (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_bus (busSat.slave)
    );

    assign bus.roscRef    = roscRef;
    assign bus.roscStr    = roscStr;
    assign busSat.roscRef = roscRef;
    assign busSat.roscStr = roscStr;

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator models: square waves with a period in CLK cycles,
    // updated on the falling edge so sampling is never ambiguous.
    // A period of 0 holds the output low.
    initial begin
        tick = 0;
        roscRef = '0;
        roscStr = '0;
        forever begin
            @(negedge clk);
            tick = tick + 1;
            for (int c = 0; c < 3; c++) begin
                roscRef[c] = (refPer[c] == 0) ? 1'b0 : ((tick % refPer[c]) < (refPer[c] / 2));
                roscStr[c] = (strPer[c] == 0) ? 1'b0 : ((tick % strPer[c]) < (strPer[c] / 2));
            end
        end
    end

    // Safety net against a hung simulation
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            if (lo == hi)
                $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, lo);
            else
                $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Selected channel gets the requested periods, others a distinct
    // period-6 pattern that would corrupt counts if the mux picked them.
    task automatic setPeriods(input int ch, input int rp, input int sp);
        for (int c = 0; c < 3; c++) begin
            refPer[c] = (c == ch) ? rp : 6;
            strPer[c] = (c == ch) ? sp : 6;
        end
    endtask

    // Pulses start for one cycle; returns 1 ns after the sampling edge.
    task automatic applyStimulus(input logic [1:0] ch, input int win);
        @(posedge clk);
        #1;
        bus.chSel  = ch;
        bus.winLen = win[15:0];
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
    endtask

    vec_t vecs [5];
    int   doneCnt;
    int   lat;

    initial begin
        checks = 0;
        errors = 0;
        for (int c = 0; c < 3; c++) begin
            refPer[c] = 0;
            strPer[c] = 0;
        end

        vecs[0] = '{2'd1, 100,  8, 10, 1'b1, 12, 13, 10,  2,  3};
        vecs[1] = '{2'd0,  40, 10,  8, 1'b1,  4,  4,  5, -1, -1};
        vecs[2] = '{2'd2,   0,  4,  4, 1'b1,  0,  0,  0,  0,  0};
        vecs[3] = '{2'd3,  50,  8,  8, 1'b0,  0,  0,  0,  0,  0};
        vecs[4] = '{2'd2,  60, 12, 20, 1'b1,  5,  5,  3,  2,  2};

        // ---------------- reset and AC stress ----------------
        rstn = 1'b0;
        bus.start = 1'b0;    bus.chSel = '0;    bus.winLen = '0;    bus.acStress = 1'b1;
        busSat.start = 1'b0; busSat.chSel = '0; busSat.winLen = '0; busSat.acStress = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_str_en_c1", bus.strEn, 0, 0);
        @(posedge clk); #1;
        checkOutput("rst_ref_en", bus.refEn, 0, 0);
        checkOutput("rst_str_en", bus.strEn, 0, 0);
        checkOutput("rst_busy", bus.busy, 0, 0);
        checkOutput("rst_done", bus.done, 0, 0);
        checkOutput("rst_ref_cnt", bus.refCnt, 0, 0);
        checkOutput("rst_str_cnt", bus.strCnt, 0, 0);
        checkOutput("rst_diff", bus.diff, 0, 0);
        checkOutput("rst_sat", bus.sat, 0, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        checkOutput("ac_str_en", bus.strEn, 7, 7);
        checkOutput("ac_ref_en", bus.refEn, 0, 0);

        // ---------------- table-driven measurements ----------------
        for (int i = 0; i < 5; i++) begin
            setPeriods(vecs[i].chSel, vecs[i].refPer, vecs[i].strPer);
            applyStimulus(vecs[i].chSel, vecs[i].winLen);
            $display("[TB] vector %0d ch=%0d win=%0d", i, vecs[i].chSel, vecs[i].winLen);
            checkOutput("busy_after_start", bus.busy, vecs[i].accept, vecs[i].accept);
            doneCnt = 0;
            lat = -1;
            for (int k = 1; k <= 150; k++) begin
                @(posedge clk); #1;
                if (k == 4 && vecs[i].accept) begin
                    checkOutput("ref_en_settle", bus.refEn, 1 << vecs[i].chSel, 1 << vecs[i].chSel);
                    checkOutput("str_en_settle", bus.strEn, 1 << vecs[i].chSel, 1 << vecs[i].chSel);
                end
                if (k == 10 && vecs[i].accept && vecs[i].winLen > 2) begin
                    checkOutput("ref_en_count", bus.refEn, 1 << vecs[i].chSel, 1 << vecs[i].chSel);
                    checkOutput("str_en_count", bus.strEn, 1 << vecs[i].chSel, 1 << vecs[i].chSel);
                end
                if (k == 3 && !vecs[i].accept) begin
                    checkOutput("rejected_busy", bus.busy, 0, 0);
                end
                if (bus.done) begin
                    doneCnt++;
                    if (lat < 0) lat = k;
                end
            end
            checkOutput("done_count", doneCnt, vecs[i].accept, vecs[i].accept);
            if (vecs[i].accept) begin
                checkOutput("latency", lat, 12 + vecs[i].winLen, 12 + vecs[i].winLen);
                checkOutput("ref_cnt", bus.refCnt, vecs[i].refMin, vecs[i].refMax);
                checkOutput("str_cnt", bus.strCnt, vecs[i].strExp, vecs[i].strExp);
                checkOutput("diff", $signed(bus.diff), vecs[i].diffMin, vecs[i].diffMax);
                checkOutput("sat", bus.sat, 0, 0);
            end
            checkOutput("idle_str_en", bus.strEn, 7, 7);
            checkOutput("idle_ref_en", bus.refEn, 0, 0);
            checkOutput("idle_busy", bus.busy, 0, 0);
        end

        // ---------------- overlapping START and AC_STRESS change ----------------
        setPeriods(1, 10, 10);
        applyStimulus(2'd1, 50);
        doneCnt = 0;
        lat = -1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
        end
        bus.acStress = 1'b0;
        applyStimulus(2'd0, 30);
        for (int k = 21; k <= 160; k++) begin
            @(posedge clk); #1;
            if (k == 25) begin
                checkOutput("ovl_str_en_busy", bus.strEn, 2, 2);
                checkOutput("ovl_busy", bus.busy, 1, 1);
            end
            if (bus.done) begin
                doneCnt++;
                if (lat < 0) lat = k;
            end
        end
        checkOutput("ovl_done_count", doneCnt, 1, 1);
        checkOutput("ovl_latency", lat, 62, 62);
        checkOutput("ovl_ref_cnt", bus.refCnt, 5, 5);
        checkOutput("ovl_str_cnt", bus.strCnt, 5, 5);
        checkOutput("ovl_diff", $signed(bus.diff), 0, 0);
        checkOutput("dc_str_en_idle", bus.strEn, 0, 0);
        bus.acStress = 1'b1;

        // ---------------- reset mid-COUNT ----------------
        setPeriods(1, 8, 10);
        applyStimulus(2'd1, 100);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_rst_busy", bus.busy, 0, 0);
        checkOutput("mid_rst_done", bus.done, 0, 0);
        checkOutput("mid_rst_ref_en", bus.refEn, 0, 0);
        checkOutput("mid_rst_str_en", bus.strEn, 0, 0);
        checkOutput("mid_rst_ref_cnt", bus.refCnt, 0, 0);
        checkOutput("mid_rst_str_cnt", bus.strCnt, 0, 0);
        checkOutput("mid_rst_diff", bus.diff, 0, 0);
        rstn = 1'b1;
        doneCnt = 0;
        @(posedge clk); #1;
        checkOutput("post_rst_str_en", bus.strEn, 7, 7);
        for (int k = 0; k < 130; k++) begin
            @(posedge clk); #1;
            if (bus.done) doneCnt++;
        end
        checkOutput("post_rst_no_done", doneCnt, 0, 0);

        // ---------------- saturation (4-bit counters) ----------------
        for (int run = 0; run < 2; run++) begin
            refPer[0] = 4;
            strPer[0] = (run == 0) ? 0 : 4;
            @(posedge clk); #1;
            busSat.chSel  = 2'd0;
            busSat.winLen = 16'd200;
            busSat.start  = 1'b1;
            @(posedge clk); #1;
            busSat.start  = 1'b0;
            doneCnt = 0;
            lat = -1;
            for (int k = 1; k <= 230; k++) begin
                @(posedge clk); #1;
                if (busSat.done) begin
                    doneCnt++;
                    if (lat < 0) lat = k;
                end
            end
            checkOutput("sat_done_count", doneCnt, 1, 1);
            checkOutput("sat_latency", lat, 212, 212);
            checkOutput("sat_ref_cnt", busSat.refCnt, 15, 15);
            checkOutput("sat_str_cnt", busSat.strCnt, (run == 0) ? 0 : 15, (run == 0) ? 0 : 15);
            checkOutput("sat_flags", busSat.sat, (run == 0) ? 2 : 3, (run == 0) ? 2 : 3);
            checkOutput("sat_diff", $signed(busSat.diff), (run == 0) ? 15 : 0, (run == 0) ? 15 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
